// File: rtl/adc_read_ad7476_if.sv
// Signal bundle between the AD7476 reader and its surroundings: the sample
// strobe/result side plus the three serial pins of the converter.
`timescale 1ns/1ps
interface adc_read_ad7476_if;
  logic        start;
  logic        sdata;
  logic        cs;
  logic        sclk;
  logic        busy;
  logic [11:0] adc;
  logic        valid;
  logic        frame_err;

  modport master (
    input  start, sdata,
    output cs, sclk, busy, adc, valid, frame_err
  );

  modport slave (
    output start, sdata,
    input  cs, sclk, busy, adc, valid, frame_err
  );
endinterface

// File: rtl/adc_read_ad7476.sv
// AD7476-class serial ADC reader: drives CS/SCLK, shifts in a 16-bit frame
// (4 leading zeros + D11..D0) and presents the 12-bit sample with a valid pulse.
`timescale 1ns/1ps
module adc_read_ad7476 #(
  parameter int SCLK_HALF    = 5,
  parameter int QUIET_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_read_ad7476_if.master bus
);

  localparam int CNT_W = $clog2(2 * SCLK_HALF + QUIET_CYCLES);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(SCLK_HALF);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(2 * SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, QUIET} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       per, per_nx;

  logic             cs_q, sclk_q, busy_q, valid_q, frame_err_q;
  logic [11:0]      adc_q;
  logic             cs_nx, sclk_nx, busy_nx, valid_nx, capture;

  logic             sdata_p0, sdata_p1;
  logic [15:0]      shreg;

  // State register; cs/sclk/busy/valid are registered from their next values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      per         <= '0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      adc_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      per     <= per_nx;
      cs_q    <= cs_nx;
      sclk_q  <= sclk_nx;
      busy_q  <= busy_nx;
      valid_q <= valid_nx;
      if (valid_nx) begin
        adc_q       <= shreg[11:0];
        frame_err_q <= |shreg[15:12];
      end
    end
  end

  // Next-state: cnt counts cycles within a phase, per counts SCLK periods
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    per_nx   = per;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = LEAD;
          cnt_nx   = '0;
          per_nx   = '0;
        end
      end
      LEAD: begin
        if (cnt == HALF_LAST) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == PER_LAST) begin
          cnt_nx = '0;
          if (per == 4'd15) state_nx = QUIET;
          else              per_nx   = per + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      QUIET: begin
        if (cnt == QUIET_LAST) state_nx = IDLE;
        else                   cnt_nx   = cnt + 1'b1;
      end
    endcase
  end

  // Outputs; a bit is captured just before each falling edge (period 16 captures nothing)
  always_comb begin
    cs_nx    = 1'b1;
    sclk_nx  = 1'b1;
    busy_nx  = (state_nx != IDLE);
    valid_nx = (state == SHIFT) && (state_nx == QUIET);
    capture  = ((state == LEAD) && (state_nx == SHIFT)) ||
               ((state == SHIFT) && (cnt == PER_LAST) && (per != 4'd15));
    unique case (state_nx)
      LEAD:    cs_nx = 1'b0;
      SHIFT: begin
        cs_nx   = 1'b0;
        sclk_nx = (cnt_nx >= HALF);
      end
      default: ;
    endcase
  end

  // sdata is asynchronous: two-flop synchronizer ahead of the shift register
  always_ff @(posedge clk) begin
    sdata_p0 <= bus.sdata;
    sdata_p1 <= sdata_p0;
    if ((state == IDLE) && (state_nx == LEAD)) shreg <= '0;
    else if (capture)                          shreg <= {shreg[14:0], sdata_p1};
  end

  assign bus.cs        = cs_q;
  assign bus.sclk      = sclk_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.adc       = adc_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_adc_read_ad7476.sv
// Directed bench for adc_read_ad7476: main instance at H=5/Q=5 plus a sweep of
// six parameter sets, each with its own behavioural AD7476 model.
`timescale 1ns/1ps
module tb_adc_read_ad7476;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_sw_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit sweep_go = 1'b0;
  int sweep_done = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Main instance with ADC model: data launched 40 ns after each SCLK fall
  adc_read_ad7476_if mb ();
  adc_read_ad7476 #(.SCLK_HALF(5), .QUIET_CYCLES(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(mb)
  );

  logic [15:0] m_word = 16'h0000;
  initial begin : main_model
    int idx;
    idx = 0;
    mb.sdata = 1'b0;
    forever begin
      @(negedge mb.cs or negedge mb.sclk);
      if (mb.sclk) begin
        idx = 0;
        #1 mb.sdata = m_word[15];
      end else begin
        idx++;
        #40 mb.sdata = (idx < 16) ? m_word[4'(15 - idx)] : 1'b0;
      end
    end
  end

  int fr_ncsf, fr_tcs, fr_first, fr_last, fr_nfall, fr_spbad;
  int fr_cslow, fr_tv, fr_nv, fr_tb, fr_bad;

  task automatic run_frame(input logic [15:0] word, input bit inject);
    logic pcs, psclk;
    m_word = word;
    fr_ncsf = 0; fr_tcs = -1; fr_first = -1; fr_last = -1; fr_nfall = 0; fr_spbad = 0;
    fr_cslow = 0; fr_tv = -1; fr_nv = 0; fr_tb = -1; fr_bad = 0;
    @(negedge clk);
    mb.start = 1'b1;
    pcs = mb.cs;
    psclk = mb.sclk;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      mb.start = inject && (k == 3 || k == 50 || k == 170);
      if (pcs && !mb.cs) begin
        fr_ncsf++;
        if (fr_tcs < 0) fr_tcs = k;
      end
      if ((pcs != mb.cs) && !(psclk && mb.sclk)) fr_bad++;
      if (psclk && !mb.sclk) begin
        fr_nfall++;
        if (fr_last >= 0 && (k - fr_last) != 10) fr_spbad++;
        if (fr_first < 0) fr_first = k;
        fr_last = k;
      end
      if (!mb.cs) fr_cslow++;
      if (mb.valid) begin
        fr_nv++;
        if (fr_tv < 0) fr_tv = k;
      end
      if (!mb.busy && fr_tb < 0 && k > 1) fr_tb = k;
      pcs = mb.cs;
      psclk = mb.sclk;
    end
  endtask

  // Parameter sweep: random data and random launch delay within the capture window
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int H = (g < 2) ? 3 : ((g < 4) ? 5 : 8);
    localparam int Q = (g % 2 == 0) ? 1 : 5;
    localparam int DMAX = (((2 * H - 2) * 10 - 5) < 60) ? ((2 * H - 2) * 10 - 5) : 60;

    adc_read_ad7476_if sb ();
    adc_read_ad7476 #(.SCLK_HALF(H), .QUIET_CYCLES(Q)) u_sw (
      .clk(clk), .rst_n(rst_sw_n), .bus(sb)
    );

    logic [15:0] word = 16'h0000;
    int dly = 0;

    initial begin : model
      int idx;
      idx = 0;
      sb.sdata = 1'b0;
      forever begin
        @(negedge sb.cs or negedge sb.sclk);
        if (sb.sclk) begin
          idx = 0;
          #1 sb.sdata = word[15];
        end else begin
          idx++;
          #(dly) sb.sdata = (idx < 16) ? word[4'(15 - idx)] : 1'b0;
        end
      end
    end

    initial begin : stim
      int cslow;
      bit seen;
      sb.start = 1'b0;
      wait (sweep_go);
      for (int f = 0; f < 3; f++) begin
        word = {4'b0000, 12'($urandom)};
        dly = $urandom_range(DMAX, 0);
        @(negedge clk);
        sb.start = 1'b1;
        cslow = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 * H + 20 && !seen; k++) begin
          @(negedge clk);
          if (k == 0) sb.start = 1'b0;
          if (!sb.cs) cslow++;
          if (sb.valid) seen = 1'b1;
        end
        chk_eq($sformatf("sw%0d_valid", g), 32'(seen), 32'd1);
        chk_eq($sformatf("sw%0d_adc", g), 32'(sb.adc), 32'(word[11:0]));
        chk_eq($sformatf("sw%0d_ferr", g), 32'(sb.frame_err), 32'd0);
        chk_eq($sformatf("sw%0d_cslow", g), cslow, 33 * H);
        for (int k = 0; k < Q + 3 && sb.busy; k++) @(negedge clk);
        chk_eq($sformatf("sw%0d_idle", g), 32'(sb.busy), 32'd0);
        repeat (3) @(negedge clk);
      end
      sweep_done++;
    end
  end

  initial begin : main_seq
    int bad, ncsf, nv, nb, tprev, tfirst, spbad;
    logic pcs;
    mb.start = 1'b0;

    // Reset held: outputs must stay at reset values while start toggles
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mb.start = ~mb.start;
      #1;
      if (mb.cs !== 1'b1 || mb.sclk !== 1'b1 || mb.busy !== 1'b0 ||
          mb.valid !== 1'b0 || mb.adc !== 12'h000 || mb.frame_err !== 1'b0) bad++;
    end
    chk_eq("rst_hold", bad, 0);
    chk_eq("rst_adc", 32'(mb.adc), 32'h000);
    chk_eq("rst_cs", 32'(mb.cs), 32'd1);
    @(negedge clk);
    mb.start = 1'b0;
    rst_n = 1'b1;
    rst_sw_n = 1'b1;
    repeat (3) @(negedge clk);
    sweep_go = 1'b1;

    // Nominal frame
    run_frame(16'h0A5C, 1'b0);
    chk_eq("nom_cs_fall", fr_tcs, 1);
    chk_eq("nom_first_fall", fr_first, 6);
    chk_eq("nom_nfall", fr_nfall, 16);
    chk_eq("nom_sclk_period", fr_spbad, 0);
    chk_eq("nom_cslow", fr_cslow, 165);
    chk_eq("nom_valid_t", fr_tv, 166);
    chk_eq("nom_nvalid", fr_nv, 1);
    chk_eq("nom_busy_fall", fr_tb, 171);
    chk_eq("nom_cs_glitch", fr_bad, 0);
    chk_eq("nom_adc", 32'(mb.adc), 32'h0A5C);
    chk_eq("nom_ferr", 32'(mb.frame_err), 32'd0);

    // Leading-bit error with full scale, then mid scale
    run_frame(16'h4FFF, 1'b0);
    chk_eq("ferr_adc", 32'(mb.adc), 32'hFFF);
    chk_eq("ferr_flag", 32'(mb.frame_err), 32'd1);
    run_frame(16'h0800, 1'b0);
    chk_eq("mid_adc", 32'(mb.adc), 32'h800);
    chk_eq("mid_ferr", 32'(mb.frame_err), 32'd0);

    // Start held high for 1000 cycles
    m_word = 16'h0123;
    ncsf = 0; nv = 0; tprev = -1; tfirst = -1; spbad = 0;
    @(negedge clk);
    mb.start = 1'b1;
    pcs = mb.cs;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (pcs && !mb.cs) begin
        ncsf++;
        if (tprev >= 0 && (k - tprev) != 171) spbad++;
        if (tfirst < 0) tfirst = k;
        tprev = k;
      end
      if (mb.valid) nv++;
      pcs = mb.cs;
    end
    mb.start = 1'b0;
    chk_eq("held_nframes", ncsf, 6);
    chk_eq("held_first", tfirst, 1);
    chk_eq("held_spacing", spbad, 0);
    chk_eq("held_nvalid", nv, 5);
    chk_eq("held_adc", 32'(mb.adc), 32'h123);
    repeat (300) @(negedge clk);
    chk_eq("held_idle", 32'(mb.busy), 32'd0);

    // Extra starts in LEAD, SHIFT and the last QUIET cycle
    run_frame(16'h0555, 1'b1);
    chk_eq("inj_nframes", fr_ncsf, 1);
    chk_eq("inj_nvalid", fr_nv, 1);
    chk_eq("inj_valid_t", fr_tv, 166);
    chk_eq("inj_busy_fall", fr_tb, 171);
    chk_eq("inj_adc", 32'(mb.adc), 32'h555);

    // Reset during SHIFT period 8 (sclk low phase)
    m_word = 16'h0FFF;
    @(negedge clk);
    mb.start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) mb.start = 1'b0;
    end
    chk_eq("mrst_pre_sclk", 32'(mb.sclk), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_cs", 32'(mb.cs), 32'd1);
    chk_eq("mrst_sclk", 32'(mb.sclk), 32'd1);
    chk_eq("mrst_adc", 32'(mb.adc), 32'h000);
    chk_eq("mrst_valid", 32'(mb.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0; nb = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (mb.valid) nv++;
      if (mb.busy) nb++;
    end
    chk_eq("mrst_no_valid", nv, 0);
    chk_eq("mrst_no_busy", nb, 0);
    run_frame(16'h03C3, 1'b0);
    chk_eq("mrst_next_adc", 32'(mb.adc), 32'h3C3);
    chk_eq("mrst_next_ferr", 32'(mb.frame_err), 32'd0);
    chk_eq("mrst_next_valid_t", fr_tv, 166);

    for (int k = 0; k < 5000 && sweep_done < 6; k++) @(negedge clk);
    chk_eq("sweep_complete", sweep_done, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
